// File: rtl/dff_arb_pkg.sv
// Shared definitions for the round-robin write arbiter.
//   arb_state_e  : arbiter FSM states (2-bit encoding)
//   owner_width  : width of a requester index, never less than 1
//   Reset*       : reset values of the arbiter state
package dff_arb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StAck     = 2'd2
    } arb_state_e;

    function automatic int unsigned owner_width(input int unsigned num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    localparam arb_state_e ResetState  = StIdle;
    localparam logic       ResetQValid = 1'b0;
    localparam logic       ResetBusy   = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req    : request vector, one bit per requester
//   ptr    : requester with highest priority this round
//   winner : first set bit of req searching upward from ptr, wrapping to 0
//   valid  : at least one request is set
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = owner_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     offset;
    logic [IDX_W:0]       sum;

    always_comb begin
        // Rotate so that bit 0 is the requester at ptr; the lowest set bit
        // is then the distance from ptr to the winner.
        req_dbl = {req, req};
        req_rot = NUM_REQ'(req_dbl >> ptr);

        offset = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
            end
        end

        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
        end

        winner = sum[IDX_W-1:0];
        valid  = |req;
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of a shared DATA_W-bit register.
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset
//   clear   : synchronous clear of q/q_valid, aborts a pending capture
//   req     : level requests, one per requester
//   wdata   : requester i's word in bits [i*DATA_W +: DATA_W]
//   ack     : one-hot, one-cycle write acknowledge
//   q       : shared register contents
//   q_valid : q holds a written, uncleared value
//   q_owner : index of the last writer
//   busy    : a transaction is in flight
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned DATA_W  = 8,
    localparam int unsigned OWNER_W = owner_width(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         q,
    output logic                      q_valid,
    output logic [OWNER_W-1:0]        q_owner,
    output logic                      busy
);

    arb_state_e          state_q, state_d;
    logic [OWNER_W-1:0]  grant_q, grant_d;
    logic [OWNER_W-1:0]  ptr_q, ptr_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic                q_valid_q, q_valid_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;

    logic [OWNER_W-1:0]  pick_winner;
    logic                pick_valid;
    logic [DATA_W-1:0]   words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = wdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWNER_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        ack_d     = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_winner;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (clear) begin
                    // Abort: requester stays pending and ptr is untouched,
                    // so the same requester wins the next arbitration.
                    state_d = StIdle;
                end else begin
                    q_d       = words[grant_q];
                    q_valid_d = 1'b1;
                    owner_d   = grant_q;
                    ack_d     = NUM_REQ'(1) << grant_q;
                    state_d   = StAck;
                end
            end
            StAck: begin
                if (grant_q == OWNER_W'(NUM_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_q + OWNER_W'(1);
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Clear wins over any write in the same cycle; ownership is kept.
        if (clear) begin
            q_d       = '0;
            q_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ResetState;
            grant_q   <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            q_q       <= '0;
            q_valid_q <= ResetQValid;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            ack_q     <= ack_d;
        end
    end

    assign ack     = ack_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_owner = owner_q;
    assign busy    = (state_q != StIdle) ? 1'b1 : ResetBusy;

endmodule

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Round-robin write arbiter for a shared flip-flop register bank. Several requesters each present a data word. The block grants one at a time, captures the winner's word into a DATA_W-bit register, and returns a one-cycle acknowledge. It sits in front of the team's resettable D flip-flop storage and adds shared access, ownership tracking and a synchronous clear to that storage.

## Interface
- NUM_REQ, default 4: number of requesters, 2..16.
- DATA_W, default 8: width of the shared register.
- clock  in  1: single clock; all state changes on the rising edge.
- reset  in  1: asynchronous, active-low; forces all state to reset values immediately.
- clear  in  1: synchronous clear of the shared register, active-high.
- req  in  NUM_REQ: level request, one bit per requester.
- wdata  in  NUM_REQ*DATA_W: requester i's word is in bits [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ: one-hot, one-cycle write acknowledge.
- q  out  DATA_W: shared register contents.
- q_valid  out  1: q holds a written, uncleared value.
- q_owner  out  OWNER_W: index of the last writer; OWNER_W = max(1, clog2(NUM_REQ)).
- busy  out  1: FSM is not in IDLE.

## Operation
- Reset values:
  - q = 0, q_valid = 0, q_owner = 0, ack = 0, busy = 0.
  - State = IDLE, round-robin pointer ptr = 0.
- FSM states: IDLE, CAPTURE, ACK.
- IDLE:
  - If req is nonzero, pick the winner: the first set bit searching from ptr upward, wrapping at NUM_REQ-1 back to 0.
  - Latch the winner into grant and go to CAPTURE.
  - If req is zero, stay in IDLE.
- CAPTURE:
  - On the edge: q <= wdata[grant], q_valid <= 1, q_owner <= grant, ack[grant] <= 1.
  - Go to ACK.
- ACK:
  - ack stays high for exactly this one cycle.
  - On the edge: ack <= 0, ptr <= (grant+1) mod NUM_REQ, go to IDLE.
- Requester protocol:
  - Hold req and wdata stable from assertion until ack is sampled high.
  - Deassert req on the same edge that samples ack = 1.
- Request dropped early (illegal): if req[grant] drops during CAPTURE, the write and ack still complete using the latched grant.
- clear takes priority over everything except reset.
  - Any state: q <= 0, q_valid <= 0; q_owner is unchanged.
  - In CAPTURE: the write is aborted, no ack is issued, ptr is unchanged, next state is IDLE. The requester stays pending and is re-arbitrated.
  - In ACK: the ack still completes and ptr still advances; only q and q_valid are cleared.
- Simultaneous requests: exactly one grant per transaction. Every continuously asserted requester is served within NUM_REQ transactions.
- Reset asserted mid-transaction: all outputs go to reset values immediately; no ack is issued.

## Timing
- Latency: req sampled high at edge k (IDLE) → grant at k → q updated and ack high after edge k+1 → ack low after edge k+2.
- Throughput: one write per 3 cycles. Back-to-back transactions from different requesters: a new grant is possible at the edge leaving ACK+1, i.e. edge k+3.
- busy is high from edge k until edge k+2.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset deassertion is synchronized externally. The first arbitration is the first edge with reset high.

## Structure
- Shared package dff_arb_pkg:
  - State enum {IDLE, CAPTURE, ACK}, 2-bit encoding.
  - OWNER_W computation function.
  - Reset-value constants.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req, ptr.
  - Outputs: winner index and any-valid flag.
  - Parameterized by NUM_REQ.
- The top level holds the FSM, the grant and ptr registers, and the DATA_W-bit storage register with the clear mux.

## Test plan
- Reset with req = 4'b1111 held → q = 0, ack = 0, busy = 0 throughout; after release, first ack is ack = 4'b0001 and q = wdata[0].
- req = 4'b1111 held, words 8'hA0..8'hA3 → acks in order 0,1,2,3,0, each 3 cycles apart; q_owner follows the same order.
- ptr = 2 with req = 4'b0011 → grant 0 (wrap), q = 8'hA0, ptr becomes 1.
- clear pulsed in the CAPTURE cycle of requester 1 → q = 0, q_valid = 0, no ack; requester 1 is re-granted next and q = 8'hA1.
- reset asserted in the ACK cycle → ack drops immediately, q = 0, state IDLE, ptr = 0.
- Single requester 3 with req held continuously → ack every 3 cycles; no other ack bit ever asserts.
